// File: rtl/sigmoid_backward_q15.sv
// Gradient pass of the Q1.15 piecewise-linear sigmoid: dx = g * 0.5 inside (-0.5, +0.5), 0 outside.
// Two-stage valid/ready pipeline with per-tile saturation counting and framing checks.
module sigmoid_backward_q15 #(
  parameter int FRAME_LEN  = 9,
  parameter int GRAD_SHIFT = 1,
  localparam int SAT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_g,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_dx,
  output logic             out_last,
  output logic [SAT_W-1:0] out_sat,
  output logic             err_frame
);

  localparam int DATA_W = 16;
  localparam int IDX_W  = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic signed [DATA_W-1:0] LIN_LO   = 16'shC000;
  localparam logic signed [DATA_W-1:0] LIN_HI   = 16'sh4000;

  function automatic logic in_linear(input logic signed [DATA_W-1:0] x);
    return (x > LIN_LO) && (x < LIN_HI);
  endfunction

  // Arithmetic shift floors toward -inf; |g/2| always fits, so no saturation stage is needed.
  function automatic logic signed [DATA_W-1:0] scale_grad(input logic signed [DATA_W-1:0] g);
    return g >>> GRAD_SHIFT;
  endfunction

  logic                     adv;
  logic                     take;
  logic                     x_sat;
  logic                     tile_end;
  logic                     close_tile;
  logic [SAT_W-1:0]         tile_total;

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [SAT_W-1:0]         sat_cnt_q, sat_cnt_d;
  logic                     err_q, err_d;

  logic                     vld_p1_q, vld_p1_d;
  logic signed [DATA_W-1:0] dx_p1_q, dx_p1_d;
  logic                     last_p1_q, last_p1_d;
  logic [SAT_W-1:0]         sat_p1_q, sat_p1_d;

  logic                     vld_p2_q, vld_p2_d;
  logic signed [DATA_W-1:0] dx_p2_q, dx_p2_d;
  logic                     last_p2_q, last_p2_d;
  logic [SAT_W-1:0]         sat_p2_q, sat_p2_d;

  always_comb begin
    idx_d     = idx_q;
    sat_cnt_d = sat_cnt_q;
    err_d     = err_q;
    vld_p1_d  = vld_p1_q;
    dx_p1_d   = dx_p1_q;
    last_p1_d = last_p1_q;
    sat_p1_d  = sat_p1_q;
    vld_p2_d  = vld_p2_q;
    dx_p2_d   = dx_p2_q;
    last_p2_d = last_p2_q;
    sat_p2_d  = sat_p2_q;

    adv        = !vld_p2_q || out_ready;
    take       = in_valid && adv;
    x_sat      = !in_linear(in_x);
    tile_end   = (idx_q == IDX_LAST);
    // The producer's in_last closes a tile early; the internal count closes it on time.
    close_tile = tile_end || in_last;
    tile_total = sat_cnt_q + {{(SAT_W-1){1'b0}}, x_sat};

    if (adv) begin
      // S1 -> S2 (output register); dx keeps its last valid value across bubbles
      vld_p2_d  = vld_p1_q;
      last_p2_d = last_p1_q;
      sat_p2_d  = sat_p1_q;
      if (vld_p1_q) begin
        dx_p2_d = dx_p1_q;
      end

      // input -> S1
      vld_p1_d = take;
      if (take) begin
        dx_p1_d   = x_sat ? '0 : scale_grad(in_g);
        last_p1_d = close_tile;
        sat_p1_d  = close_tile ? tile_total : '0;
      end else begin
        last_p1_d = 1'b0;
        sat_p1_d  = '0;
      end
    end

    if (take) begin
      idx_d     = close_tile ? '0 : idx_q + 1'b1;
      sat_cnt_d = close_tile ? '0 : tile_total;
      if (in_last != tile_end) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    dx_p1_q <= dx_p1_d;
    if (rst) begin
      idx_q     <= '0;
      sat_cnt_q <= '0;
      err_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      sat_p1_q  <= '0;
      vld_p2_q  <= 1'b0;
      dx_p2_q   <= '0;
      last_p2_q <= 1'b0;
      sat_p2_q  <= '0;
    end else begin
      idx_q     <= idx_d;
      sat_cnt_q <= sat_cnt_d;
      err_q     <= err_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      sat_p1_q  <= sat_p1_d;
      vld_p2_q  <= vld_p2_d;
      dx_p2_q   <= dx_p2_d;
      last_p2_q <= last_p2_d;
      sat_p2_q  <= sat_p2_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_p2_q;
  assign out_dx    = dx_p2_q;
  assign out_last  = last_p2_q;
  assign out_sat   = sat_p2_q;
  assign err_frame = err_q;

endmodule

// File: tb/tb_sigmoid_backward_q15.sv
// Directed bench for sigmoid_backward_q15: hand-computed vectors plus a random-stall golden run.
`timescale 1ns/1ps
module tb_sigmoid_backward_q15;

  localparam int FL = 9;
  localparam int SW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_x;
  logic [15:0]   in_g;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_dx;
  logic          out_last;
  logic [SW-1:0] out_sat;
  logic          err_frame;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [15:0] x; logic [15:0] g; logic last; } in_t;
  typedef struct packed { logic [15:0] dx; logic last; logic [SW-1:0] sat; } exp_t;

  in_t  in_q[$];
  exp_t exp_q[$];

  sigmoid_backward_q15 #(.FRAME_LEN(FL), .GRAD_SHIFT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_g(in_g), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dx(out_dx), .out_last(out_last), .out_sat(out_sat),
    .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] g, input logic last,
                      input logic [15:0] dx, input logic el, input logic [SW-1:0] es);
    in_t  a;
    exp_t b;
    a = '{x: x, g: g, last: last};
    b = '{dx: dx, last: el, sat: es};
    in_q.push_back(a);
    exp_q.push_back(b);
  endtask

  // Streams in_q into the DUT and matches every output beat against exp_q.
  task automatic run(input bit rand_ready, input int budget);
    int          n = 0;
    bit          held_v = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] cur;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_q.size() > 0) begin
        in_valid = 1'b1;
        in_x     = in_q[0].x;
        in_g     = in_q[0].g;
        in_last  = in_q[0].last;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      cur = 32'({out_valid, out_dx, out_last, out_sat});
      if (held_v) chk("stall_hold", cur, held);
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'(0));
      held_v = out_valid && !out_ready;
      held   = cur;
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          chk("beat", 32'({out_dx, out_last, out_sat}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) void'(in_q.pop_front());
      cyc();
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    chk("run_complete", 32'(in_q.size() + exp_q.size()), 32'(0));
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic idle_chk(input int n);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("no_stray_beat", 32'(out_valid), 32'(0));
      cyc();
    end
  endtask

  initial begin
    logic [15:0] x, g, dx;
    int          xi, gi, dxi, m_idx, m_sat;
    logic        lin, lst;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_g = '0; in_last = 1'b0; out_ready = 1'b0;

    // T1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_dx", 32'(out_dx), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_out_sat", 32'(out_sat), 32'(0));
    chk("rst_err_frame", 32'(err_frame), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    // T2: linear region, latency of exactly 2 cycles
    out_ready = 1'b1; in_valid = 1'b1; in_x = 16'h0000; in_g = 16'h2000; in_last = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk("lat_cycle1_valid", 32'(out_valid), 32'(0));
    cyc();
    chk("lat_cycle2_valid", 32'(out_valid), 32'(1));
    chk("lin_dx_2000", 32'(out_dx), 32'(16'h1000));
    cyc();
    chk("after_beat_valid", 32'(out_valid), 32'(0));
    push(16'h0000, 16'h8001, 1'b0, 16'hC000, 1'b0, '0);
    run(1'b0, 50);

    // T3: region boundaries
    push(16'hC000, 16'h7FFE, 1'b0, 16'h0000, 1'b0, '0);
    push(16'hC001, 16'h7FFE, 1'b0, 16'h3FFF, 1'b0, '0);
    push(16'h3FFF, 16'h7FFE, 1'b0, 16'h3FFF, 1'b0, '0);
    push(16'h4000, 16'h7FFE, 1'b0, 16'h0000, 1'b0, '0);
    run(1'b0, 50);

    // T4: two aligned tiles after a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    push(16'h0000, 16'h0100, 1'b0, 16'h0080, 1'b0, '0);
    push(16'h4000, 16'h1234, 1'b0, 16'h0000, 1'b0, '0);
    push(16'h2000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, '0);
    push(16'h8000, 16'h7FFF, 1'b0, 16'h0000, 1'b0, '0);
    push(16'hE000, 16'h0002, 1'b0, 16'h0001, 1'b0, '0);
    push(16'hC000, 16'h1000, 1'b0, 16'h0000, 1'b0, '0);
    push(16'h3FFF, 16'h8000, 1'b0, 16'hC000, 1'b0, '0);
    push(16'hC001, 16'h0003, 1'b0, 16'h0001, 1'b0, '0);
    push(16'h1000, 16'hFFFE, 1'b1, 16'hFFFF, 1'b1, SW'(3));
    for (int k = 1; k <= 9; k++) begin
      push(16'h0000, 16'(16 * k), k == 9, 16'(8 * k), k == 9, '0);
    end
    run(1'b0, 100);
    chk("t4_err_frame", 32'(err_frame), 32'(0));

    // T5: random stalls against the golden model, framing kept aligned
    m_idx = 0;
    m_sat = 0;
    for (int k = 0; k < 100; k++) begin
      x   = 16'($urandom);
      g   = 16'($urandom);
      xi  = $signed(x);
      gi  = $signed(g);
      lin = (xi > -16384) && (xi < 16384);
      dxi = lin ? (gi - (gi & 1)) / 2 : 0;
      dx  = 16'(dxi);
      lst = (m_idx == FL - 1);
      if (!lin) m_sat++;
      push(x, g, lst, dx, lst, lst ? SW'(m_sat) : '0);
      if (lst) begin
        m_idx = 0;
        m_sat = 0;
      end else begin
        m_idx++;
      end
    end
    run(1'b1, 3000);
    chk("t5_err_frame", 32'(err_frame), 32'(0));

    // T6: early in_last, resync, then reset mid-tile
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    push(16'h0000, 16'h0200, 1'b0, 16'h0100, 1'b0, '0);
    push(16'h7FFF, 16'h0400, 1'b0, 16'h0000, 1'b0, '0);
    push(16'h0000, 16'h0600, 1'b0, 16'h0300, 1'b0, '0);
    push(16'h0000, 16'h0800, 1'b0, 16'h0400, 1'b0, '0);
    push(16'h0000, 16'h0A00, 1'b1, 16'h0500, 1'b1, SW'(1));
    run(1'b0, 50);
    chk("t6_err_set", 32'(err_frame), 32'(1));
    for (int k = 0; k < 9; k++) begin
      push((k == 0 || k == 3) ? 16'h8000 : 16'h0000, 16'h0020, k == 8,
           (k == 0 || k == 3) ? 16'h0000 : 16'h0010, k == 8, (k == 8) ? SW'(2) : '0);
    end
    run(1'b0, 100);
    chk("t6_err_sticky", 32'(err_frame), 32'(1));

    out_ready = 1'b0; in_valid = 1'b1; in_x = 16'h0000; in_g = 16'h0100; in_last = 1'b0;
    cyc();
    in_g = 16'h0200;
    cyc();
    in_valid = 1'b0;
    chk("t6_stalled_valid", 32'(out_valid), 32'(1));
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'(0));
    chk("t6_rst_dx", 32'(out_dx), 32'(0));
    chk("t6_rst_err", 32'(err_frame), 32'(0));
    idle_chk(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
